ex_mul: RTL
===========

# ex_mul

Iterative shift-add multiplier on the execute side of the ID/EX pipeline register. It consumes the registered `ex_*` operation bundle and executes the RV32M multiply group (MUL, MULH, MULHSU, MULHU) over multiple cycles. While busy it raises a stall request to pipeline control, so ID/EX holds its contents. It returns a single-cycle result with write-back address and enable for the EX/MEM path.

## Interface
Parameters:
- `XLEN`, 32, operand/result width; iteration count equals `XLEN`.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-low (0 = reset).
- `ex_alusel`  in  `AluSelBus`  operation class; unit engages only on `EXE_RES_MUL`.
- `ex_aluop`  in  `AluOpBus`  one of `EXE_MUL_OP`, `EXE_MULH_OP`, `EXE_MULHSU_OP`, `EXE_MULHU_OP`.
- `ex_opv1`  in  `XLEN`  multiplicand (rs1 value).
- `ex_opv2`  in  `XLEN`  multiplier (rs2 value).
- `ex_waddr`  in  `RegAddrBus`  destination register.
- `ex_we`  in  1  destination write enable.
- `flush`  in  1  synchronous abort of the in-flight multiply (branch/exception).
- `mul_stallreq`  out  1  stall request to pipeline control.
- `mul_valid`  out  1  result valid, one-cycle pulse.
- `mul_wdata`  out  `XLEN`  result.
- `mul_waddr`  out  `RegAddrBus`  latched destination.
- `mul_we`  out  1  latched `ex_we` qualified by `mul_valid`.

## Operation
- FSM states: IDLE, BUSY, DONE.
- Start condition: state IDLE, `ex_alusel == EXE_RES_MUL`, `flush == 0`.
- IDLE:
  - On start, latch `|opv1|`, `|opv2|`, the result sign, the aluop, `ex_waddr`, and `ex_we`. Clear the 64-bit accumulator and the count. Go to BUSY.
  - Signedness: MULH treats both operands as signed; MULHSU treats opv1 as signed and opv2 as unsigned; MULHU and MUL treat both as unsigned. MUL uses the low half, which is sign-independent.
- BUSY, each cycle:
  - If multiplier bit0 = 1, add the shifted multiplicand into the accumulator.
  - Shift the multiplicand left 1 (64-bit) and the multiplier right 1; increment the count.
  - After count `XLEN-1`, go to DONE.
- DONE:
  - Apply two's-complement negation of the 64-bit product if sign = 1.
  - `mul_wdata` is the low half for MUL and the high half otherwise.
  - `mul_valid` = 1; go to IDLE unconditionally.
  - The start condition is ignored in DONE, because ID/EX still holds the same instruction that cycle.
- `mul_stallreq` is combinational:
  - 1 in IDLE when the start condition holds;
  - 1 throughout BUSY;
  - 0 in DONE.
- `flush` = 1 in BUSY: next state IDLE, no `mul_valid`, and `mul_stallreq` drops in the flush cycle itself.
- `flush` = 1 in DONE: `mul_valid` and `mul_we` are forced to 0.
- An unknown aluop with `EXE_RES_MUL` behaves as MUL.

## Timing
- Reset, asynchronous: state IDLE, accumulator/operands/count = 0. All outputs 0: `mul_stallreq`, `mul_valid`, `mul_wdata`, `mul_waddr`, `mul_we`.
- Reset mid-operation aborts immediately; no result is produced after release.
- Start accepted in cycle T; BUSY for T+1..T+32; DONE with `mul_valid` = 1 at T+33.
- `mul_stallreq` is high T..T+32 (33 cycles) and low at T+33, so ID/EX advances on the edge ending T+33.
- Back-to-back multiplies: the second start is at T+34 at the earliest.
- `mul_wdata` and `mul_waddr` are registered; they hold their last values outside DONE. Only `mul_valid` and `mul_we` are pulses.

## Configuration
- `MUL_EARLY_OUT_EN` defined:
  - In BUSY, after processing a bit, if the remaining shifted multiplier is 0, go to DONE on that edge.
  - Latency becomes (index of highest set bit of `|opv2|`) + 1 BUSY cycles, minimum 1. `|opv2|` = 0 reaches DONE at T+2.
  - `mul_stallreq` follows state, as specified above.
- Not defined: a fixed 32 BUSY cycles; the remaining-multiplier comparator is not built.

## Test plan
- MUL, opv1 = 7, opv2 = 6, waddr = 5, we = 1 -> stallreq high T..T+32; at T+33 `mul_valid` = 1, `mul_wdata` = 42, `mul_waddr` = 5, `mul_we` = 1.
- MULH 0xFFFFFFFF × 0xFFFFFFFF -> `mul_wdata` = 0x00000000. MULHU with the same operands -> 0xFFFFFFFE. MUL with the same operands -> 0x00000001.
- MULHSU, opv1 = 0xFFFFFFFF, opv2 = 2 -> `mul_wdata` = 0xFFFFFFFF. MULH 0x80000000 × 0x80000000 -> 0x40000000.
- MUL 3 × 4 with `flush` at T+10 -> stallreq low at T+10, no `mul_valid` through T+40, state IDLE. `rst` = 0 at T+5 -> all outputs 0 immediately, no later `mul_valid`.
- With `MUL_EARLY_OUT_EN`: MUL 5 × 3 -> `mul_valid` at T+3, `mul_wdata` = 15. MULH 0xFFFFFFFF × 0xFFFFFFFF -> `mul_valid` at T+2, `mul_wdata` = 0. Without the macro, both complete at T+33.
- Two MULs held back-to-back in ID/EX (4×4, then 2×3) -> results 16 at T+33 and 6 at T+67, with no duplicate start during DONE.

Source files
------------

// File: rtl/ex_mul_if.sv
// ex_mul_if: ID/EX multiply bundle into ex_mul and its write-back result
interface ex_mul_if #(parameter int XLEN = 32);
    logic [2:0]      ex_alusel;
    logic [7:0]      ex_aluop;
    logic [XLEN-1:0] ex_opv1;
    logic [XLEN-1:0] ex_opv2;
    logic [4:0]      ex_waddr;
    logic            ex_we;
    logic            flush;
    logic            mul_stallreq;
    logic            mul_valid;
    logic [XLEN-1:0] mul_wdata;
    logic [4:0]      mul_waddr;
    logic            mul_we;
    modport master (
        output ex_alusel, ex_aluop, ex_opv1, ex_opv2, ex_waddr, ex_we, flush,
        input  mul_stallreq, mul_valid, mul_wdata, mul_waddr, mul_we
    );
    modport slave (
        input  ex_alusel, ex_aluop, ex_opv1, ex_opv2, ex_waddr, ex_we, flush,
        output mul_stallreq, mul_valid, mul_wdata, mul_waddr, mul_we
    );
endinterface

// File: rtl/ex_mul.sv
// ex_mul: iterative shift-add RV32M multiplier; MUL_EARLY_OUT_EN ends BUSY once the remaining multiplier is zero
module ex_mul #(parameter int XLEN = 32) (
    input logic clk,
    input logic rst,
    ex_mul_if.slave bus
);
    localparam logic [2:0] EXE_RES_MUL   = 3'b110;
    localparam logic [7:0] EXE_MUL_OP    = 8'h18;
    localparam logic [7:0] EXE_MULH_OP   = 8'h19;
    localparam logic [7:0] EXE_MULHSU_OP = 8'h1A;
    localparam logic [7:0] EXE_MULHU_OP  = 8'h1B;
    localparam int CW = $clog2(XLEN);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t r_state, w_next;
    logic [2*XLEN-1:0] r_mcand, r_acc, w_sum, w_prod;
    logic [XLEN-1:0]   r_mplier, r_wdata, w_a1, w_a2, w_res;
    logic [CW-1:0]     r_cnt;
    logic [4:0]        r_waddr, r_out_waddr;
    logic              r_sign, r_hi, r_we;
    logic              w_start, w_last, w_is_mulh, w_is_mulhsu, w_is_mulhu;
    logic              w_stall, w_valid;
    // Reset low also masks the start so every output reads 0 during reset.
    assign w_start     = rst && r_state == IDLE && bus.ex_alusel == EXE_RES_MUL && !bus.flush;
    assign w_is_mulh   = bus.ex_aluop == EXE_MULH_OP;
    assign w_is_mulhsu = bus.ex_aluop == EXE_MULHSU_OP;
    assign w_is_mulhu  = bus.ex_aluop == EXE_MULHU_OP;
    assign w_a1 = ((w_is_mulh || w_is_mulhsu) && bus.ex_opv1[XLEN-1]) ? -bus.ex_opv1 : bus.ex_opv1;
    assign w_a2 = (w_is_mulh && bus.ex_opv2[XLEN-1]) ? -bus.ex_opv2 : bus.ex_opv2;
    // The final partial product is folded in on the edge into DONE.
    assign w_sum  = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_prod = r_sign ? -w_sum : w_sum;
    assign w_res  = r_hi ? w_prod[2*XLEN-1:XLEN] : w_prod[XLEN-1:0];
`ifdef MUL_EARLY_OUT_EN
    assign w_last = r_cnt == CW'(XLEN-1) || r_mplier[XLEN-1:1] == '0;
`else
    assign w_last = r_cnt == CW'(XLEN-1);
`endif
    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end
    // Next state, stall request and result strobe
    always_comb begin
        w_next  = r_state;
        w_stall = 1'b0;
        w_valid = 1'b0;
        case (r_state)
            IDLE: begin
                w_stall = w_start;
                w_next  = w_start ? BUSY : IDLE;
            end
            BUSY: begin
                w_stall = !bus.flush;
                w_next  = bus.flush ? IDLE : (w_last ? DONE : BUSY);
            end
            DONE: begin
                w_valid = !bus.flush;
                w_next  = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end
    // Operand latch, shift-add datapath and registered result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_sign      <= 1'b0;
            r_hi        <= 1'b0;
            r_we        <= 1'b0;
            r_waddr     <= '0;
            r_out_waddr <= '0;
            r_wdata     <= '0;
        end else if (w_start) begin
            r_mcand  <= {{XLEN{1'b0}}, w_a1};
            r_mplier <= w_a2;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_sign   <= w_is_mulh ? (bus.ex_opv1[XLEN-1] ^ bus.ex_opv2[XLEN-1]) :
                        w_is_mulhsu ? bus.ex_opv1[XLEN-1] : 1'b0;
            r_hi     <= w_is_mulh || w_is_mulhsu || w_is_mulhu;
            r_we     <= bus.ex_we;
            r_waddr  <= bus.ex_waddr;
        end else if (r_state == BUSY) begin
            r_acc    <= w_sum;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CW'(1);
            if (w_last && !bus.flush) begin
                r_wdata     <= w_res;
                r_out_waddr <= r_waddr;
            end
        end
    end
    assign bus.mul_stallreq = w_stall;
    assign bus.mul_valid    = w_valid;
    assign bus.mul_wdata    = r_wdata;
    assign bus.mul_waddr    = r_out_waddr;
    assign bus.mul_we       = w_valid && r_we;
endmodule
